sophiali_hex_display: RTL
=========================

// Module: sophiali_hex_display
// PURPOSE
//  Display-side consumer for the 8-bit accumulator result. Receives a byte serially
//  (data pin + shift button, MSB first) and latches it on a latch button. Shows it as two
//  hex digits on a single time-multiplexed 7-segment bus with a digit-select line.
//  Button inputs are synchronised and rising-edge detected: a held button acts once.
// PARAMETERS
//  CNT_W   12  refresh counter width; digit period = 2^(CNT_W-rate) clocks (CNT_W >= 4)
// PORTS
//  clock    in   1  system clock
//  reset    in   1  asynchronous, active-high; clock clock
//  sdata    in   1  serial data bit, sampled on shift edge (async pin, synchronised)
//  shift    in   1  shift button/strobe, level (async, synchronised, rising-edge used)
//  latch    in   1  latch button, level (async, synchronised, rising-edge used)
//  blank    in   1  level; 1 forces all segments off (async, synchronised)
//  rate     in   2  refresh rate select, 0 = slowest, 3 = fastest (quasi-static)
//  seg      out  7  segments {g,f,e,d,c,b,a}, active-high, registered
//  dig_sel  out  1  0 = low-nibble digit driven, 1 = high-nibble digit, registered
//  loaded   out  1  1 when >= 8 bits have been shifted since the last latch/reset
// BEHAVIOUR
//  Reset (async): sync/edge flops=0, sr=0, disp=0, bit_cnt=0, cnt=0, dig_sel=0,
//   seg=7'h3F (digit 0), loaded=0. Reset mid-shift discards partial byte.
//  Sync: each of sdata/shift/latch/blank passes through 2 flops (s1,s2). shift/latch
//   also keep prev=s2; edge = s2 & ~prev (one-cycle pulse).
//  Shift: on shift edge, sr <= {sr[6:0], sdata_s2}; bit_cnt saturates at 8.
//   Pin rise -> sr updated on 3rd clock edge. More than 8 shifts keep shifting.
//   The last 8 bits win.
//  Latch: on latch edge, disp <= sr; bit_cnt <= 0. Shift edge in the same cycle:
//   disp takes the pre-shift sr, sr still shifts, bit_cnt = 1.
//   Latch with bit_cnt < 8 is legal and copies sr as is.
//  loaded = (bit_cnt == 8), combinational from the bit_cnt register.
//  Refresh: P = 2^(CNT_W-rate). tick = (cnt >= P-1).
//   On tick: cnt <= 0, dig_sel toggles. Otherwise cnt <= cnt + 1.
//   Rate raised while cnt > new P-1: tick on the next cycle.
//   Digit 0/1 each shown for P clocks.
//  Seg register, updated every cycle together with dig_sel:
//   seg <= blank_s2 ? 7'h00 : hex7(next_dig_sel ? disp[7:4] : disp[3:0]).
//   Seg always matches dig_sel in the same cycle. A new disp appears on seg 1 cycle later.
//   Blank pin -> seg off on 3rd edge; dig_sel and cnt keep running while blanked.
//  hex7 table, 0..F:
//   3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71
// STRUCTURE
//  Package sophiali_disp_pkg: typedef logic [6:0] seg_t; SEG_BLANK = 7'h00;
//   function hex7(logic [3:0]) returning seg_t; default CNT_W constant.
//  Sub-module sophiali_sync_edge: 2-flop synchroniser + rising-edge pulse, async reset.
//   Instantiated for shift and latch. sdata/blank use bare 2-flop sync.
//  Top holds sr/bit_cnt, disp, refresh counter, dig_sel/seg registers.
// TESTING (bench uses CNT_W=4)
//  1 Assert reset mid-operation -> seg=3F, dig_sel=0, loaded=0 immediately (async).
//  2 Shift 0xA5 MSB first (8 pulses), loaded=1, pulse latch.
//    -> dig_sel=0 shows 6D, dig_sel=1 shows 77, loaded=0.
//  3 Hold shift high 20 cycles with sdata=1 from sr=0 -> sr=0x01 (single shift), bit_cnt=1.
//  4 rate=0 -> dig_sel toggles every 16 clocks; rate=3 -> every 2.
//    Switch 0->3 at cnt=10 -> toggle next cycle.
//  5 sr=0x3C, shift(sdata=1) and latch edges coincide -> disp=0x3C, sr=0x79, bit_cnt=1.
//  6 blank=1 -> seg=00 by 3rd edge while dig_sel keeps toggling; blank=0 -> digits return.

Source files
------------

// File: rtl/sophiali_disp_pkg.sv
// Shared types and the hex-to-segment decoder for the accumulator result display.
package sophiali_disp_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK     = 7'h00;
    localparam int   CNT_W_DEFAULT = 12;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    function automatic seg_t hex7(input logic [3:0] nib);
        seg_t s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sophiali_sync_edge.sv
// Two-flop synchroniser for an asynchronous button, producing a one-cycle pulse
// on each synchronised rising edge so a held button acts only once.
module sophiali_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic s1, s2, prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign pulse = s2 & ~prev;

endmodule

// File: rtl/sophiali_hex_display.sv
// Serial-in byte receiver with latch, shown as two time-multiplexed hex digits
// on one 7-segment bus with a digit-select line.
module sophiali_hex_display
    import sophiali_disp_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sdata,
    input  logic       shift,
    input  logic       latch,
    input  logic       blank,
    input  logic [1:0] rate,
    output seg_t       seg,
    output logic       dig_sel,
    output logic       loaded
);

    logic sdata_s1, sdata_s2, blank_s1, blank_s2;
    logic shift_edge, latch_edge;

    logic [7:0]       sr, disp;
    logic [3:0]       bit_cnt;
    logic [CNT_W-1:0] cnt, lim;
    logic             tick, next_dig_sel;

    // NOTE: every register, including the data byte, is cleared by reset so a
    // reset mid-shift leaves no partial byte and the display starts at digit 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sdata_s1 <= 1'b0;
            sdata_s2 <= 1'b0;
            blank_s1 <= 1'b0;
            blank_s2 <= 1'b0;
        end else begin
            sdata_s1 <= sdata;
            sdata_s2 <= sdata_s1;
            blank_s1 <= blank;
            blank_s2 <= blank_s1;
        end
    end

    sophiali_sync_edge u_shift_sync (
        .clock (clock),
        .reset (reset),
        .din   (shift),
        .pulse (shift_edge)
    );

    sophiali_sync_edge u_latch_sync (
        .clock (clock),
        .reset (reset),
        .din   (latch),
        .pulse (latch_edge)
    );

    // A coincident latch takes the pre-shift byte and restarts the count at the new bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr      <= 8'h00;
            disp    <= 8'h00;
            bit_cnt <= 4'd0;
        end else begin
            if (shift_edge)
                sr <= {sr[6:0], sdata_s2};
            if (latch_edge) begin
                disp    <= sr;
                bit_cnt <= shift_edge ? 4'd1 : 4'd0;
            end else if (shift_edge && bit_cnt != 4'd8) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    assign loaded = (bit_cnt == 4'd8);

    // NOTE: all always_comb outputs are assigned on every path so no latch is inferred.
    always_comb begin
        lim          = {CNT_W{1'b1}} >> rate;
        tick         = (cnt >= lim);
        next_dig_sel = dig_sel ^ tick;
    end

    // seg is decoded from next_dig_sel so it always matches dig_sel in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            dig_sel <= 1'b0;
            seg     <= hex7(4'h0);
        end else begin
            cnt     <= tick ? '0 : cnt + CNT_W'(1);
            dig_sel <= next_dig_sel;
            seg     <= blank_s2 ? SEG_BLANK
                                : hex7(next_dig_sel ? disp[7:4] : disp[3:0]);
        end
    end

endmodule
